// File: rtl/posit_align_add_16.sv
// Posit adder align/add stage: compare/swap, sticky right shift and significand add/subtract.
// Define POSIT_ALIGN_SINGLE_STAGE_EN to drop the compare/swap register (latency 1 instead of 2).
module posit_align_add_16 #(
    parameter int N  = 16,
    parameter int SW = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_a_sign,
    input  logic                 i_b_sign,
    input  logic signed [SW-1:0] i_a_scale,
    input  logic signed [SW-1:0] i_b_scale,
    input  logic        [N-2:0]  i_a_frac,
    input  logic        [N-2:0]  i_b_frac,
    input  logic                 i_a_zero,
    input  logic                 i_b_zero,
    input  logic                 i_a_nar,
    input  logic                 i_b_nar,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign,
    output logic signed [SW-1:0] o_scale,
    output logic        [N-1:0]  o_sum,
    output logic                 o_sticky,
    output logic                 o_zero,
    output logic                 o_nar
);

    localparam int SHW = $clog2(N);
    localparam logic [SW:0]    DiffMax = (SW+1)'(N - 1);
    localparam logic [SHW-1:0] ShMax   = (SHW)'(N - 1);

    typedef struct packed {
        logic          nar;
        logic          bothZero;
        logic          effSub;
        logic          sign;
        logic [SW-1:0] scale;
        logic [N-2:0]  largeFrac;
        logic [N-2:0]  smallFrac;
        logic [SHW-1:0] shamt;
    } stage1_t;

    logic           bIsLarge;
    logic [SW-1:0]  largeScale;
    logic [SW-1:0]  smallScale;
    logic [SW:0]    diff;
    logic           smallZero;
    stage1_t        s1_d;
    stage1_t        s2In;
    logic           s2InValid;
    logic           s2Adv;

    // A zero operand never wins the ordering; on a full tie operand a stays large.
    always_comb begin
        bIsLarge = 1'b0;
        if (i_b_zero) begin
            bIsLarge = 1'b0;
        end else if (i_a_zero) begin
            bIsLarge = 1'b1;
        end else if (i_b_scale > i_a_scale) begin
            bIsLarge = 1'b1;
        end else if ((i_b_scale == i_a_scale) && (i_b_frac > i_a_frac)) begin
            bIsLarge = 1'b1;
        end
    end

    assign largeScale = bIsLarge ? i_b_scale : i_a_scale;
    assign smallScale = bIsLarge ? i_a_scale : i_b_scale;
    assign smallZero  = bIsLarge ? i_a_zero  : i_b_zero;
    assign diff       = {largeScale[SW-1], largeScale} - {smallScale[SW-1], smallScale};

    always_comb begin
        s1_d           = '0;
        s1_d.nar       = i_a_nar | i_b_nar;
        s1_d.bothZero  = i_a_zero & i_b_zero;
        s1_d.effSub    = i_a_sign ^ i_b_sign;
        s1_d.sign      = bIsLarge ? i_b_sign : i_a_sign;
        s1_d.scale     = largeScale;
        s1_d.largeFrac = bIsLarge ? i_b_frac : i_a_frac;
        s1_d.smallFrac = smallZero ? '0 : (bIsLarge ? i_a_frac : i_b_frac);
        s1_d.shamt     = (diff >= DiffMax) ? ShMax : diff[SHW-1:0];
    end

    assign s2Adv = !o_valid | i_ready;

`ifdef POSIT_ALIGN_SINGLE_STAGE_EN
    assign s2In      = s1_d;
    assign s2InValid = i_valid;
    assign o_ready   = s2Adv;
`else
    stage1_t s1_q;
    logic    s1Valid_q;
    logic    s1Adv;

    assign s1Adv = !s1Valid_q | s2Adv;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1Valid_q <= 1'b0;
            s1_q      <= '0;
        end else if (s1Adv) begin
            s1Valid_q <= i_valid;
            if (i_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    assign s2In      = s1_q;
    assign s2InValid = s1Valid_q;
    assign o_ready   = s1Adv;
`endif

    logic [N-2:0]  shifted;
    logic          stickyBit;
    logic [N-1:0]  sumRaw;
    logic          cancel;
    logic          sign_d;
    logic [SW-1:0] scale_d;
    logic [N-1:0]  sum_d;
    logic          sticky_d;
    logic          zero_d;
    logic          nar_d;

    // Log shifter: each level collects the bits it drops into the sticky bit.
    always_comb begin
        shifted   = s2In.smallFrac;
        stickyBit = 1'b0;
        for (int k = SHW - 1; k >= 0; k--) begin
            if (s2In.shamt[k]) begin
                for (int j = 0; j < N - 1; j++) begin
                    if (j < (1 << k)) begin
                        stickyBit = stickyBit | shifted[j];
                    end
                end
                shifted = shifted >> (1 << k);
            end
        end
    end

    // The sticky borrow is folded into the difference so the downstream rounder sees a truncated value.
    always_comb begin
        if (s2In.effSub) begin
            sumRaw = {1'b0, s2In.largeFrac} - {1'b0, shifted} - {{(N-1){1'b0}}, stickyBit};
        end else begin
            sumRaw = {1'b0, s2In.largeFrac} + {1'b0, shifted};
        end
        cancel = s2In.effSub && (sumRaw == '0) && !stickyBit;

        sign_d   = s2In.sign;
        scale_d  = s2In.scale;
        sum_d    = sumRaw;
        sticky_d = stickyBit;
        zero_d   = 1'b0;
        nar_d    = 1'b0;
        if (s2In.nar) begin
            sign_d   = 1'b0;
            scale_d  = '0;
            sum_d    = '0;
            sticky_d = 1'b0;
            nar_d    = 1'b1;
        end else if (s2In.bothZero || cancel) begin
            sign_d   = 1'b0;
            scale_d  = '0;
            sum_d    = '0;
            sticky_d = 1'b0;
            zero_d   = 1'b1;
        end
    end

    logic          valid_q;
    logic          sign_q;
    logic [SW-1:0] scale_q;
    logic [N-1:0]  sum_q;
    logic          sticky_q;
    logic          zero_q;
    logic          nar_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            sign_q   <= 1'b0;
            scale_q  <= '0;
            sum_q    <= '0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
            nar_q    <= 1'b0;
        end else if (s2Adv) begin
            valid_q <= s2InValid;
            if (s2InValid) begin
                sign_q   <= sign_d;
                scale_q  <= scale_d;
                sum_q    <= sum_d;
                sticky_q <= sticky_d;
                zero_q   <= zero_d;
                nar_q    <= nar_d;
            end
        end
    end

    assign o_valid  = valid_q;
    assign o_sign   = sign_q;
    assign o_scale  = scale_q;
    assign o_sum    = sum_q;
    assign o_sticky = sticky_q;
    assign o_zero   = zero_q;
    assign o_nar    = nar_q;

endmodule

// File: tb/tb_posit_align_add_16.sv
// Directed bench for posit_align_add_16 (default two-stage build): arithmetic vectors,
// special values, backpressure buffering and asynchronous reset.
module tb_posit_align_add_16;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_valid;
    logic              o_ready;
    logic              i_a_sign;
    logic              i_b_sign;
    logic signed [6:0] i_a_scale;
    logic signed [6:0] i_b_scale;
    logic [14:0]       i_a_frac;
    logic [14:0]       i_b_frac;
    logic              i_a_zero;
    logic              i_b_zero;
    logic              i_a_nar;
    logic              i_b_nar;
    logic              o_valid;
    logic              i_ready;
    logic              o_sign;
    logic signed [6:0] o_scale;
    logic [15:0]       o_sum;
    logic              o_sticky;
    logic              o_zero;
    logic              o_nar;

    int checks   = 0;
    int failures = 0;

    posit_align_add_16 #(.N(16), .SW(7)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_a_sign  (i_a_sign),
        .i_b_sign  (i_b_sign),
        .i_a_scale (i_a_scale),
        .i_b_scale (i_b_scale),
        .i_a_frac  (i_a_frac),
        .i_b_frac  (i_b_frac),
        .i_a_zero  (i_a_zero),
        .i_b_zero  (i_b_zero),
        .i_a_nar   (i_a_nar),
        .i_b_nar   (i_b_nar),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sign    (o_sign),
        .o_scale   (o_scale),
        .o_sum     (o_sum),
        .o_sticky  (o_sticky),
        .o_zero    (o_zero),
        .o_nar     (o_nar)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic applyStimulus(
        input logic aSign, input logic [6:0] aScale, input logic [14:0] aFrac,
        input logic aZero, input logic aNar,
        input logic bSign, input logic [6:0] bScale, input logic [14:0] bFrac,
        input logic bZero, input logic bNar);
        i_a_sign  = aSign;
        i_a_scale = aScale;
        i_a_frac  = aFrac;
        i_a_zero  = aZero;
        i_a_nar   = aNar;
        i_b_sign  = bSign;
        i_b_scale = bScale;
        i_b_frac  = bFrac;
        i_b_zero  = bZero;
        i_b_nar   = bNar;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one pair with the sink ready, then sample two edges later.
    task automatic runPair();
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        applyStimulus(0, 7'sd0, 15'h0, 0, 0, 0, 7'sd0, 15'h0, 0, 0);

        #1;
        checkOutput("rst.valid",  {31'd0, o_valid}, 0);
        checkOutput("rst.sum",    {16'd0, o_sum}, 0);
        checkOutput("rst.sticky", {31'd0, o_sticky}, 0);
        checkOutput("rst.sign",   {31'd0, o_sign}, 0);
        checkOutput("rst.scale",  {25'd0, o_scale}, 0);
        checkOutput("rst.zero",   {31'd0, o_zero}, 0);
        checkOutput("rst.nar",    {31'd0, o_nar}, 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        checkOutput("rst.ready", {31'd0, o_ready}, 1);

        applyStimulus(0, 7'sd0, 15'h4000, 0, 0, 0, 7'sd0, 15'h4000, 0, 0);
        runPair();
        checkOutput("addEq.valid",  {31'd0, o_valid}, 1);
        checkOutput("addEq.sum",    {16'd0, o_sum}, 32'h8000);
        checkOutput("addEq.scale",  {25'd0, o_scale}, 0);
        checkOutput("addEq.sign",   {31'd0, o_sign}, 0);
        checkOutput("addEq.sticky", {31'd0, o_sticky}, 0);

        applyStimulus(0, 7'sd3, 15'h4000, 0, 0, 0, 7'sd0, 15'h4001, 0, 0);
        runPair();
        checkOutput("addSticky.sum",    {16'd0, o_sum}, 32'h4800);
        checkOutput("addSticky.sticky", {31'd0, o_sticky}, 1);
        checkOutput("addSticky.scale",  {25'd0, o_scale}, 3);

        applyStimulus(0, 7'sd3, 15'h4000, 0, 0, 1, 7'sd0, 15'h4001, 0, 0);
        runPair();
        checkOutput("subBorrow.sum",    {16'd0, o_sum}, 32'h37FF);
        checkOutput("subBorrow.sticky", {31'd0, o_sticky}, 1);
        checkOutput("subBorrow.sign",   {31'd0, o_sign}, 0);

        applyStimulus(1, -7'sd10, 15'h7FFF, 0, 0, 0, 7'sd10, 15'h4000, 0, 0);
        runPair();
        checkOutput("sat.sum",    {16'd0, o_sum}, 32'h3FFF);
        checkOutput("sat.sticky", {31'd0, o_sticky}, 1);
        checkOutput("sat.sign",   {31'd0, o_sign}, 0);
        checkOutput("sat.scale",  {25'd0, o_scale}, 10);

        applyStimulus(0, 7'sd14, 15'h4000, 0, 0, 0, 7'sd0, 15'h7FFF, 0, 0);
        runPair();
        checkOutput("diff14.sum",    {16'd0, o_sum}, 32'h4001);
        checkOutput("diff14.sticky", {31'd0, o_sticky}, 1);

        applyStimulus(0, 7'sd15, 15'h4000, 0, 0, 0, 7'sd0, 15'h7FFF, 0, 0);
        runPair();
        checkOutput("diff15.sum",    {16'd0, o_sum}, 32'h4000);
        checkOutput("diff15.sticky", {31'd0, o_sticky}, 1);

        applyStimulus(0, 7'sd1, 15'h4000, 0, 0, 1, 7'sd1, 15'h6000, 0, 0);
        runPair();
        checkOutput("fracSwap.sum",   {16'd0, o_sum}, 32'h2000);
        checkOutput("fracSwap.sign",  {31'd0, o_sign}, 1);
        checkOutput("fracSwap.scale", {25'd0, o_scale}, 1);

        applyStimulus(0, 7'sd5, 15'h5555, 0, 0, 1, 7'sd5, 15'h5555, 0, 0);
        runPair();
        checkOutput("cancel.zero",  {31'd0, o_zero}, 1);
        checkOutput("cancel.sum",   {16'd0, o_sum}, 0);
        checkOutput("cancel.sign",  {31'd0, o_sign}, 0);
        checkOutput("cancel.scale", {25'd0, o_scale}, 0);

        applyStimulus(0, 7'sd2, 15'h4000, 0, 1, 0, 7'sd1, 15'h5000, 0, 0);
        runPair();
        checkOutput("nar.nar",    {31'd0, o_nar}, 1);
        checkOutput("nar.sum",    {16'd0, o_sum}, 0);
        checkOutput("nar.zero",   {31'd0, o_zero}, 0);
        checkOutput("nar.sticky", {31'd0, o_sticky}, 0);

        applyStimulus(0, 7'sd9, 15'h1234, 1, 0, 1, 7'sd2, 15'h6000, 0, 0);
        runPair();
        checkOutput("aZero.sum",   {16'd0, o_sum}, 32'h6000);
        checkOutput("aZero.sign",  {31'd0, o_sign}, 1);
        checkOutput("aZero.scale", {25'd0, o_scale}, 2);
        checkOutput("aZero.zero",  {31'd0, o_zero}, 0);

        applyStimulus(1, 7'sd4, 15'h1234, 1, 0, 1, 7'sd9, 15'h7777, 1, 0);
        runPair();
        checkOutput("bothZero.zero", {31'd0, o_zero}, 1);
        checkOutput("bothZero.sum",  {16'd0, o_sum}, 0);
        checkOutput("bothZero.sign", {31'd0, o_sign}, 0);

        @(posedge i_clk);
        #1;
        checkOutput("drain.valid", {31'd0, o_valid}, 0);

        i_ready = 1'b0;
        applyStimulus(0, 7'sd0, 15'h4000, 0, 0, 0, 7'sd0, 15'h4000, 0, 0);
        i_valid = 1'b1;
        checkOutput("bp.readyP1", {31'd0, o_ready}, 1);
        @(posedge i_clk);
        #1;
        checkOutput("bp.readyP2", {31'd0, o_ready}, 1);
        applyStimulus(0, 7'sd3, 15'h4000, 0, 0, 0, 7'sd0, 15'h4001, 0, 0);
        @(posedge i_clk);
        #1;
        applyStimulus(0, 7'sd6, 15'h7000, 0, 0, 0, 7'sd6, 15'h7000, 0, 0);
        checkOutput("bp.full",   {31'd0, o_ready}, 0);
        checkOutput("bp.valid1", {31'd0, o_valid}, 1);
        checkOutput("bp.sum1",   {16'd0, o_sum}, 32'h8000);
        @(posedge i_clk);
        #1;
        checkOutput("bp.stillFull", {31'd0, o_ready}, 0);
        checkOutput("bp.holdValid", {31'd0, o_valid}, 1);
        checkOutput("bp.holdSum",   {16'd0, o_sum}, 32'h8000);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("bp.valid2",  {31'd0, o_valid}, 1);
        checkOutput("bp.sum2",    {16'd0, o_sum}, 32'h4800);
        checkOutput("bp.sticky2", {31'd0, o_sticky}, 1);
        checkOutput("bp.scale2",  {25'd0, o_scale}, 3);
        @(posedge i_clk);
        #1;
        checkOutput("bp.third", {31'd0, o_valid}, 0);

        i_ready = 1'b0;
        applyStimulus(0, 7'sd0, 15'h4000, 0, 0, 0, 7'sd0, 15'h4000, 0, 0);
        runPair();
        checkOutput("midRst.before", {31'd0, o_valid}, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midRst.valid", {31'd0, o_valid}, 0);
        checkOutput("midRst.sum",   {16'd0, o_sum}, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("midRst.dropped", {31'd0, o_valid}, 0);

        applyStimulus(0, 7'sd3, 15'h4000, 0, 0, 1, 7'sd0, 15'h4001, 0, 0);
        runPair();
        checkOutput("postRst.valid", {31'd0, o_valid}, 1);
        checkOutput("postRst.sum",   {16'd0, o_sum}, 32'h37FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/posit_align_add_16.md
# posit_align_add_16

Two-stage pipelined alignment-and-add stage of the posit adder. It takes two decoded posit operands (sign, scale, normalized significand), orders them by magnitude and computes the scale difference. It then right-shifts the smaller significand with sticky collection and adds or subtracts the significands. The raw sum goes to the downstream normalize/round/encode stage under a valid/ready handshake.

## Interface
- `N`, 16: posit width; significands are N-1 bits; shift amount is $clog2(N) bits
- `SW`, 7: signed scale width (two's complement)
- `i_clk` in 1: clock, rising edge
- `i_rst_n` in 1: asynchronous active-low reset
- `i_valid` in 1: upstream operand pair valid
- `o_ready` out 1: stage can accept an operand pair this cycle
- `i_a_sign`, `i_b_sign` in 1: operand signs
- `i_a_scale`, `i_b_scale` in SW: signed scales
- `i_a_frac`, `i_b_frac` in N-1: significands; bit N-2 is the hidden 1 for nonzero operands
- `i_a_zero`, `i_b_zero` in 1: operand is zero; scale and frac are ignored
- `i_a_nar`, `i_b_nar` in 1: operand is NaR
- `o_valid` out 1: result valid
- `i_ready` in 1: downstream accepts the result
- `o_sign` out 1: result sign
- `o_scale` out SW: scale of the larger operand
- `o_sum` out N: unnormalized magnitude; bit N-1 is the carry
- `o_sticky` out 1: OR of all significand bits shifted out
- `o_zero`, `o_nar` out 1: special-result flags

## Operation
- Stage 1 (compare/swap), registered:
  - NaR flag = a_nar | b_nar.
  - Large operand = the one with the greater scale. On equal scales it is the one with the greater frac. On full tie it is a.
  - A zero operand is always the small operand. Both zero gives result zero.
  - diff = large_scale - small_scale, unsigned, computed at SW+1 bits. Saturate diff to N-1 when diff ≥ N-1.
  - eff_sub = a_sign ^ b_sign. Result sign = large sign.
  - When the small operand is zero, its frac is forced to 0.
- Stage 2 (shift/add), registered:
  - Shift: small frac shifted right by diff[$clog2(N)-1:0] with pad bit 0, as a log-shifter of levels 8/4/2/1. sticky = OR of every bit discarded at any level. At diff = N-1 the shifted value is 0 and sticky = |small_frac.
  - Add: o_sum = {0,large} + {0,shifted}.
  - Subtract: o_sum = {0,large} - {0,shifted} - sticky. The sticky borrow is taken here, so the true value is o_sum plus a nonzero fraction below the LSB. o_sticky passes through unchanged.
  - o_zero = 1 when both inputs are zero, or on subtraction with o_sum == 0 and sticky == 0. In that case o_sign = 0 and o_scale = 0.
  - o_nar = 1 forces o_sum = 0, o_sticky = 0, o_sign = 0, o_zero = 0.
- Ordering guarantees o_sum ≥ 0. No negative result is ever produced.

## Timing
- Latency 2 cycles from accepted input (i_valid & o_ready) to o_valid. Throughput 1 per cycle.
- Each stage holds a valid bit.
  - s2_adv = !s2_valid | i_ready
  - s1_adv = !s1_valid | s2_adv
  - o_ready = s1_adv, combinational from i_ready.
- Backpressure: with i_ready = 0, o_valid and every output field hold stable. At most 2 pairs are buffered, then o_ready = 0.
- Simultaneous accept and output consume in one cycle: both stages advance with no bubble.
- Reset (asynchronous assert, synchronous deassert by the system):
  - s1_valid = s2_valid = 0, all datapath registers 0.
  - o_valid = 0, o_sum = 0, o_sticky = 0, o_sign = 0, o_scale = 0, o_zero = 0, o_nar = 0.
  - o_ready = 1 once reset is released.
  - Reset mid-operation drops in-flight pairs silently.

## Configuration
- `POSIT_ALIGN_SINGLE_STAGE_EN` defined:
  - Stage 1 register is removed; compare/swap feeds shift/add combinationally.
  - Latency 1 cycle, o_ready = !s2_valid | i_ready, at most 1 pair buffered.
- Undefined (default): two-stage pipeline as above.
- Results are bit-identical in both builds.

## Test plan
- Add equal: a = b = (+, scale 0, frac 0x4000), i_ready = 1.
  - 2 cycles later: o_sum = 0x8000, o_scale = 0, o_sign = 0, o_sticky = 0.
- Aligned add with sticky: a = (+, 3, 0x4000), b = (+, 0, 0x4001).
  - o_sum = 0x4800, o_sticky = 1, o_scale = 3.
- Aligned subtract with borrow: a = (+, 3, 0x4000), b = (-, 0, 0x4001).
  - o_sum = 0x37FF, o_sticky = 1, o_sign = 0.
- Saturation and swap: a = (-, -10, 0x7FFF), b = (+, 10, 0x4000).
  - diff 20 saturates to 15.
  - o_sum = 0x3FFF, o_sticky = 1, o_sign = 0, o_scale = 10.
- Cancellation and specials:
  - a = (+, 5, 0x5555), b = (-, 5, 0x5555) gives o_zero = 1, o_sum = 0.
  - a_nar = 1 with any b gives o_nar = 1, o_sum = 0.
- Backpressure and reset:
  - Hold i_ready = 0 and offer 3 back-to-back pairs. Exactly 2 are accepted, then o_ready = 0 and outputs stay stable.
  - Raise i_ready: both results emerge in order on consecutive cycles.
  - Assert i_rst_n = 0 mid-stream: o_valid = 0 immediately.
